// File: rtl/i2c_prog_master.sv
// Single-byte I2C write / random-read engine for the instruction-memory programming port.
// One request yields START, device address, register address, data (or RSTART + read), STOP.
module i2c_prog_master #(
    parameter int         CLK_DIV  = 25,
    parameter logic [6:0] DEV_ADDR = 7'h2A
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic [7:0] o_rdata,
    output logic       o_scl,
    output logic       o_sda_oe,
    input  logic       i_sda_in
);

    localparam int QW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND_BYTE,
        ST_GET_ACK,
        ST_RSTART,
        ST_RECV_BYTE,
        ST_SEND_NACK,
        ST_STOP
    } state_t;

    state_t        state_reg, state_next;
    logic [QW-1:0] q_cnt_reg, q_cnt_next;
    logic [1:0]    qtr_reg, qtr_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    // Byte slot: 0 dev addr (W), 1 register addr, 2 write data, 3 dev addr (R)
    logic [1:0]    byte_idx_reg, byte_idx_next;
    logic [7:0]    tx_reg, tx_next;
    logic [7:0]    rx_reg, rx_next;
    logic          rw_reg, rw_next;
    logic [7:0]    addr_reg, addr_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic          sample_reg, sample_next;
    logic          ack_err_reg, ack_err_next;
    logic [7:0]    rdata_reg, rdata_next;
    logic          done_reg, done_next;
    logic          sda_meta_reg, sda_sync_reg;

    logic q_end, bit_end;

    assign q_end   = (q_cnt_reg == QW'(CLK_DIV - 1));
    assign bit_end = q_end && (qtr_reg == 2'd3);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            q_cnt_reg    <= '0;
            qtr_reg      <= '0;
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            rw_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            sample_reg   <= 1'b0;
            ack_err_reg  <= 1'b0;
            rdata_reg    <= '0;
            done_reg     <= 1'b0;
            sda_meta_reg <= 1'b1;
            sda_sync_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            q_cnt_reg    <= q_cnt_next;
            qtr_reg      <= qtr_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_idx_reg <= byte_idx_next;
            tx_reg       <= tx_next;
            rx_reg       <= rx_next;
            rw_reg       <= rw_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            sample_reg   <= sample_next;
            ack_err_reg  <= ack_err_next;
            rdata_reg    <= rdata_next;
            done_reg     <= done_next;
            sda_meta_reg <= i_sda_in;
            sda_sync_reg <= sda_meta_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        q_cnt_next    = q_cnt_reg;
        qtr_next      = qtr_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_idx_next = byte_idx_reg;
        tx_next       = tx_reg;
        rx_next       = rx_reg;
        rw_next       = rw_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        sample_next   = sample_reg;
        ack_err_next  = ack_err_reg;
        rdata_next    = rdata_reg;
        done_next     = 1'b0;

        // Quarter timing runs whenever a transaction is active; qtr wraps 3->0 at bit end
        if (state_reg != ST_IDLE) begin
            if (q_end) begin
                q_cnt_next = '0;
                qtr_next   = qtr_reg + 2'd1;
            end else begin
                q_cnt_next = q_cnt_reg + QW'(1);
            end
            if (qtr_reg == 2'd2 && q_end) begin
                sample_next = sda_sync_reg;
                if (state_reg == ST_RECV_BYTE)
                    rx_next = {rx_reg[6:0], sda_sync_reg};
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    rw_next      = i_rw;
                    addr_next    = i_addr;
                    wdata_next   = i_wdata;
                    ack_err_next = 1'b0;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_next       = {DEV_ADDR, 1'b0};
                    bit_cnt_next  = 3'd7;
                    byte_idx_next = 2'd0;
                    state_next    = ST_SEND_BYTE;
                end
            end
            ST_SEND_BYTE: begin
                if (bit_end) begin
                    if (bit_cnt_reg == 3'd0)
                        state_next = ST_GET_ACK;
                    else
                        bit_cnt_next = bit_cnt_reg - 3'd1;
                end
            end
            ST_GET_ACK: begin
                if (bit_end) begin
                    bit_cnt_next = 3'd7;
                    if (sample_reg) begin
                        ack_err_next = 1'b1;
                        state_next   = ST_STOP;
                    end else begin
                        case (byte_idx_reg)
                            2'd0: begin
                                tx_next       = addr_reg;
                                byte_idx_next = 2'd1;
                                state_next    = ST_SEND_BYTE;
                            end
                            2'd1: begin
                                if (rw_reg) begin
                                    state_next = ST_RSTART;
                                end else begin
                                    tx_next       = wdata_reg;
                                    byte_idx_next = 2'd2;
                                    state_next    = ST_SEND_BYTE;
                                end
                            end
                            2'd2:    state_next = ST_STOP;
                            default: state_next = ST_RECV_BYTE;
                        endcase
                    end
                end
            end
            ST_RSTART: begin
                if (bit_end) begin
                    tx_next       = {DEV_ADDR, 1'b1};
                    bit_cnt_next  = 3'd7;
                    byte_idx_next = 2'd3;
                    state_next    = ST_SEND_BYTE;
                end
            end
            ST_RECV_BYTE: begin
                if (bit_end) begin
                    if (bit_cnt_reg == 3'd0)
                        state_next = ST_SEND_NACK;
                    else
                        bit_cnt_next = bit_cnt_reg - 3'd1;
                end
            end
            ST_SEND_NACK: begin
                // Only reachable when every ACK was good, so the byte is valid here
                if (bit_end) begin
                    rdata_next = rx_reg;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Line levels are decoded from registered state so reset releases both at once
    always_comb begin
        o_scl    = 1'b1;
        o_sda_oe = 1'b0;
        case (state_reg)
            ST_START: begin
                o_scl    = 1'b1;
                o_sda_oe = qtr_reg[1];
            end
            ST_SEND_BYTE: begin
                o_scl    = (qtr_reg == 2'd1) || (qtr_reg == 2'd2);
                o_sda_oe = ~tx_reg[bit_cnt_reg];
            end
            ST_GET_ACK, ST_RECV_BYTE, ST_SEND_NACK: begin
                o_scl    = (qtr_reg == 2'd1) || (qtr_reg == 2'd2);
                o_sda_oe = 1'b0;
            end
            ST_RSTART: begin
                o_scl    = (qtr_reg != 2'd0);
                o_sda_oe = qtr_reg[1];
            end
            ST_STOP: begin
                o_scl    = (qtr_reg != 2'd0);
                o_sda_oe = ~qtr_reg[1];
            end
            default: begin
                o_scl    = 1'b1;
                o_sda_oe = 1'b0;
            end
        endcase
    end

    assign o_busy    = (state_reg != ST_IDLE);
    assign o_done    = done_reg;
    assign o_ack_err = ack_err_reg;
    assign o_rdata   = rdata_reg;

endmodule

// File: doc/i2c_prog_master.md
# i2c_prog_master

I2C controller-side engine that programs and reads back the processor's instruction memory over its I2C programming port. It issues one complete single-byte write or random read transaction per request: START, device address, register address, data, STOP. It drives SCL and an open-drain SDA enable. The block sits on the host/test-harness side of the programming bus, opposite the on-chip I2C target.

## Interface
Parameters:
- `CLK_DIV`, default 25: `i_clk` cycles per quarter bit period. Must be ≥ 3. One bit period is `4*CLK_DIV` cycles.
- `DEV_ADDR`, default 7'h2A: 7-bit target address.

Ports:
- `i_clk`  in  1  single clock; all logic rising-edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  request; accepted only in IDLE.
- `i_rw`  in  1  0 = write, 1 = read.
- `i_addr`  in  8  instruction-memory address byte.
- `i_wdata`  in  8  write data byte; ignored for reads.
- `o_busy`  out  1  transaction in progress.
- `o_done`  out  1  one-cycle completion pulse.
- `o_ack_err`  out  1  last transaction saw a NACK.
- `o_rdata`  out  8  last successfully read byte.
- `o_scl`  out  1  SCL, push-pull; 1 = high. No clock stretching is supported.
- `o_sda_oe`  out  1  1 = pull SDA low, 0 = release.
- `i_sda_in`  in  1  SDA line level; passes through a 2-FF synchronizer before use.

## Operation
- **States:** IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_NACK, STOP.
- **Request capture:** In IDLE with `i_start=1`, the block latches `i_rw`, `i_addr` and `i_wdata`, clears `o_ack_err`, and enters START.
- **Write sequence:** START, byte `{DEV_ADDR,0}`, ACK, `i_addr`, ACK, `i_wdata`, ACK, STOP.
- **Read sequence:** START, `{DEV_ADDR,0}`, ACK, `i_addr`, ACK, RSTART, `{DEV_ADDR,1}`, ACK, 8 bits received, NACK (SDA released), STOP.
- **Bit order:** Bytes are sent MSB first. The bit counter runs 7 down to 0.
- **Data bit quarters (Q0–Q3):**
  - Q0: SCL=0; SDA updated at Q0 start.
  - Q1, Q2: SCL=1.
  - Q3: SCL=0.
  - SDA is sampled (synchronized) on the last cycle of Q2.
- **Master SDA drive:** when sending a 1, or during ACK/RECV bits, the master releases SDA (`o_sda_oe=0`).
- **START (from idle):** Q0–Q1 SCL=1, SDA released; Q2–Q3 SCL=1, SDA low.
- **RSTART:** Q0 SCL=0, SDA released; Q1 SCL=1, SDA released; Q2–Q3 SCL=1, SDA low.
- **STOP:** Q0 SCL=0, SDA low; Q1 SCL=1, SDA low; Q2–Q3 SCL=1, SDA released.
- **ACK handling:** A sampled 1 during any GET_ACK is a NACK. On NACK, `o_ack_err` is set and the block goes directly to STOP; remaining bytes are skipped.
- **Read data:** On completion of a read with no NACK, `o_rdata` is loaded with the received byte. Otherwise `o_rdata` holds its previous value.
- **Completion:** After the STOP's Q3, the block returns to IDLE. `o_done=1` for exactly that first IDLE cycle.
- **Requests while busy:** `i_start` while busy is ignored; it is neither queued nor latched.
- **Back-to-back requests:** A request presented in the `o_done` cycle is accepted, since that cycle is IDLE.
- **Reset values:**
  - `o_scl=1`, `o_sda_oe=0`
  - `o_busy=0`, `o_done=0`
  - `o_ack_err=0`, `o_rdata=8'h00`
  - state IDLE; all counters 0.
- **Reset mid-transaction:** both lines are released immediately (asynchronously) and no STOP is generated. Recovering the target is the host's responsibility (target-side `i2c_rst`).

## Timing
- **Acceptance latency:** `i_start` is sampled on edge N. `o_busy=1` and START Q0 are present from cycle N+1.
- **`o_busy` pulse:** stays high for exactly `P*4*CLK_DIV` cycles, then falls in the `o_done` cycle.
  - Successful write: P = 29 (1 + 3×9 + 1).
  - Successful read: P = 39 (1 + 9 + 9 + 1 + 9 + 9 + 1).
  - NACK after byte k (1-based): P = 1 + 9k + 1.
- **SDA change constraint:** SDA changes only while SCL=0, except in START, RSTART and STOP.
- **SCL period:** exactly `4*CLK_DIV` cycles with 50% duty.
- **Synchronizer margin:** synchronizer latency (2 cycles) is less than the Q1 + Q2 high time, because `CLK_DIV ≥ 3`.

## Test plan
- **Write, ACKing target model** (`CLK_DIV=4`, addr 0x10, data 0xA5):
  - Bus carries START, 0x54, 0x10, 0xA5, STOP, with ACK after each byte.
  - `o_busy` high 464 cycles, single `o_done`, `o_ack_err=0`.
- **Read** (addr 0x04, target returns 0x3C):
  - Bus carries 0x54, 0x04, RSTART, 0x55, then the target's 0x3C, master NACK, STOP.
  - `o_rdata=0x3C` at `o_done`; busy 624 cycles.
- **Device-address NACK** (target absent):
  - STOP follows the 9th SCL pulse; `o_ack_err=1`; busy 176 cycles.
  - `o_rdata` unchanged on a read.
- **Busy and back-to-back requests:**
  - Pulse `i_start` with new operands mid-write: no effect on bus bytes.
  - `i_start` held in the `o_done` cycle: a new transaction starts the next cycle.
- **Reset mid-transaction:** assert `i_rst` during bit 3 of the data byte.
  - Same cycle: `o_scl=1`, `o_sda_oe=0`, `o_busy=0`.
  - After release, a fresh write completes normally.
- **Phase checks:** run the write with `CLK_DIV=3`.
  - Monitor asserts SDA never changes while SCL=1 outside START/RSTART/STOP.
  - Each SCL high phase is 6 cycles.
